// File: rtl/bht_pkg.sv
// Shared types for the BHT update path: queued update payload and issue-FSM states.
package bht_pkg;

   localparam int unsigned BHT_IDX_W = 12;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned STAT_W    = 16;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
   } upd_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_DEFER = 2'd2,
      ST_FORCE = 2'd3
   } issue_state_e;

endpackage

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO of pending BHT updates; head entry is visible without a pop.
module bht_upd_fifo
   import bht_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  upd_entry_t       push_data_i,
   input  logic             pop_i,
   output upd_entry_t       head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   localparam int unsigned PW = PTR_W + 1;

   upd_entry_t       mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra wrap bit separates full from empty when the index bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count_o = PW'(wr_ptr_q - rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = PW'(wr_ptr_q + PW'(1));
      end
      if (do_pop) begin
         rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is only consumed while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT update-port sequencer: queues resolved branches, defers index collisions with fetch,
// pulses a fetch redirect on mispredict and keeps saturating branch statistics.
module bht_update_ctrl
   import bht_pkg::*;
#(
   parameter int unsigned IDX_W     = BHT_IDX_W,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_DEFER = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_pc,
   input  logic              ex_taken,
   input  logic              ex_predicted,
   input  logic [31:0]       ex_target,
   input  logic [31:0]       lookup_pc,
   output logic [31:0]       updata_pc,
   output logic              updata_taken,
   output logic              updata_enable,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   input  logic              stat_clr,
   output logic [15:0]       stat_branches,
   output logic [15:0]       stat_mispredicts
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_FW = PTR_W + 1;
   localparam int unsigned DEF_W = 3;

   upd_entry_t          push_entry;
   upd_entry_t          head;
   logic                fifo_full, fifo_empty;
   logic [PTR_W:0]      fifo_count;

   logic                accept, mispredict;
   logic                head_valid, conflict, issue;
   logic                unused_lookup_bits;

   issue_state_e        state_q, state_d;
   logic [DEF_W-1:0]    defer_cnt_q, defer_cnt_d;

   logic                redirect_valid_q;
   logic [31:0]         redirect_pc_q, redirect_pc_d;
   logic [STAT_W-1:0]   branches_q, branches_d;
   logic [STAT_W-1:0]   mispredicts_q, mispredicts_d;

   assign ex_ready   = !fifo_full;
   assign accept     = ex_valid && ex_ready;
   assign mispredict = accept && (ex_taken != ex_predicted);

   assign push_entry.pc    = ex_pc;
   assign push_entry.taken = ex_taken;

   bht_upd_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (accept),
      .push_data_i(push_entry),
      .pop_i      (issue),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   // Only the BHT index bits take part in the collision test.
   assign head_valid = !fifo_empty;
   assign conflict   = (head.pc[IDX_W+1:2] == lookup_pc[IDX_W+1:2]);
   assign issue      = head_valid && (!conflict || (state_q == ST_FORCE));
   assign unused_lookup_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

   // Issue FSM: FORCE is reached exactly when defer_cnt hits MAX_DEFER.
   always_comb begin
      state_d       = state_q;
      defer_cnt_d   = defer_cnt_q;
      updata_enable = 1'b0;
      updata_pc     = '0;
      updata_taken  = 1'b0;
      if (!head_valid) begin
         defer_cnt_d = '0;
         state_d     = accept ? ST_READY : ST_IDLE;
      end else if (issue) begin
         updata_enable = 1'b1;
         updata_pc     = head.pc;
         updata_taken  = head.taken;
         defer_cnt_d   = '0;
         state_d       = (accept || (fifo_count > CNT_FW'(1))) ? ST_READY : ST_IDLE;
      end else begin
         defer_cnt_d = DEF_W'(defer_cnt_q + DEF_W'(1));
         state_d     = (defer_cnt_d == DEF_W'(MAX_DEFER)) ? ST_FORCE : ST_DEFER;
      end
   end

   // Redirect target and saturating statistics; clear beats a same-cycle event.
   always_comb begin
      redirect_pc_d = redirect_pc_q;
      branches_d    = branches_q;
      mispredicts_d = mispredicts_q;
      if (mispredict) begin
         redirect_pc_d = ex_taken ? ex_target : 32'(ex_pc + 32'd4);
      end
      if (stat_clr) begin
         branches_d = '0;
      end else if (accept && (branches_q != '1)) begin
         branches_d = STAT_W'(branches_q + STAT_W'(1));
      end
      if (stat_clr) begin
         mispredicts_d = '0;
      end else if (mispredict && (mispredicts_q != '1)) begin
         mispredicts_d = STAT_W'(mispredicts_q + STAT_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         defer_cnt_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         branches_q       <= '0;
         mispredicts_q    <= '0;
      end else begin
         state_q          <= state_d;
         defer_cnt_q      <= defer_cnt_d;
         redirect_valid_q <= mispredict;
         redirect_pc_q    <= redirect_pc_d;
         branches_q       <= branches_d;
         mispredicts_q    <= mispredicts_d;
      end
   end

   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign stat_branches    = branches_q;
   assign stat_mispredicts = mispredicts_q;

endmodule
